// File: rtl/cdb_pkg.sv
// Shared types and constants for the common data bus arbiter.
package cdb_pkg;

  localparam int unsigned TAG_W   = 8;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ENTRY_W = TAG_W + DATA_W;

  // One broadcast result: tag in the upper byte, data below it.
  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } cdb_entry_t;

  // Tag value that marks "no result".
  localparam logic [TAG_W-1:0] TAG_NONE = 8'h00;

  // Unit and reservation-station tags.
  localparam logic [TAG_W-1:0] ADD   = 8'h03;
  localparam logic [TAG_W-1:0] MULTI = 8'h04;
  localparam logic [TAG_W-1:0] A0    = 8'h20;
  localparam logic [TAG_W-1:0] A1    = 8'h21;
  localparam logic [TAG_W-1:0] A2    = 8'h22;
  localparam logic [TAG_W-1:0] M0    = 8'h30;
  localparam logic [TAG_W-1:0] M1    = 8'h31;
  localparam logic [TAG_W-1:0] LD0   = 8'h40;
  localparam logic [TAG_W-1:0] LD1   = 8'h41;

  // Requester indices on the arbiter.
  localparam int unsigned REQ_ADD  = 0;
  localparam int unsigned REQ_MULT = 1;
  localparam int unsigned REQ_LOAD = 2;

endpackage

// File: rtl/cdb_fifo.sv
// Per-requester circular result buffer; DEPTH must be a power of two.
module cdb_fifo
  import cdb_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  cdb_entry_t    wdata,
  output cdb_entry_t    rdata,
  output logic [CW-1:0] count
);

  cdb_entry_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Ignore push when full and pop when empty so count can never wrap.
  assign do_push = push && (count < CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign rdata   = mem[rd_ptr];

  // Storage array; contents are don't-care while the entry is unoccupied.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (!do_push && do_pop) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing one registered common data bus between
// the add, multiply and load units. Optional stall statistics are
// compiled in with the CDB_STATS_EN macro.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DEPTH   = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*ENTRY_W-1:0] req_bus,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       cdb_valid,
  output logic [ENTRY_W-1:0]         cdb_bus,
  output logic [NUM_REQ-1:0]         cdb_grant
`ifdef CDB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]      stall_cnt
`endif
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [PW-1:0]      rr_ptr;
  logic [CW-1:0]      count [NUM_REQ];
  cdb_entry_t         head  [NUM_REQ];
  logic [NUM_REQ-1:0] push;
  logic [NUM_REQ-1:0] pop;
  logic               found_c;
  logic [PW-1:0]      winner_c;

  // One buffer per requester; zero-tag transfers are acknowledged but dropped.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    cdb_entry_t entry_in;

    assign entry_in      = cdb_entry_t'(req_bus[gi*ENTRY_W +: ENTRY_W]);
    assign req_ready[gi] = (count[gi] < CW'(DEPTH));
    assign push[gi]      = req_valid[gi] & req_ready[gi] & (entry_in.tag != TAG_NONE);

    cdb_fifo #(
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[gi]),
      .pop   (pop[gi]),
      .wdata (entry_in),
      .rdata (head[gi]),
      .count (count[gi])
    );
  end

  // Round-robin search starting at rr_ptr; first non-empty buffer wins.
  always_comb begin
    found_c  = 1'b0;
    winner_c = '0;
    pop      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      int unsigned   sum;
      logic [PW-1:0] idx;
      sum = 32'(rr_ptr) + k;
      if (sum >= NUM_REQ) begin
        sum = sum - NUM_REQ;
      end
      idx = PW'(sum);
      if (!found_c && (count[idx] != '0)) begin
        found_c  = 1'b1;
        winner_c = idx;
      end
    end
    if (found_c) begin
      pop[winner_c] = 1'b1;
    end
  end

  // Registered broadcast and pointer advance; idle cycles drive all zeros.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cdb_valid <= 1'b0;
      cdb_bus   <= '0;
      cdb_grant <= '0;
      rr_ptr    <= '0;
    end else if (found_c) begin
      cdb_valid <= 1'b1;
      cdb_bus   <= head[winner_c];
      cdb_grant <= pop;
      rr_ptr    <= (winner_c == PW'(NUM_REQ - 1)) ? '0 : winner_c + 1'b1;
    end else begin
      cdb_valid <= 1'b0;
      cdb_bus   <= '0;
      cdb_grant <= '0;
    end
  end

`ifdef CDB_STATS_EN
  // Saturating count of cycles each requester waits on a full buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && !req_ready[i] && (stall_cnt[i*16 +: 16] != 16'hFFFF)) begin
          stall_cnt[i*16 +: 16] <= stall_cnt[i*16 +: 16] + 16'd1;
        end
      end
    end
  end
`else
  // Stall statistics are not built in this configuration.
`endif

endmodule
